// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register outstanding-write counters gating issue on RAW/WAW hazards
// Ports: clk/reset_n (async active-low); iss_* issue handshake with two sources, a destination
//   and an rflags write; wb0/wb1 writeback retire ports; flush discards in-flight writes;
//   busy_vec = nonzero counters, err = sticky protocol error, stall_cnt = saturating stall cycles.
// Optional: define SB_WB_BYPASS_EN for same-cycle writeback wakeup of RAW sources.
module reg_scoreboard #(
  parameter int REG_CNT = 18,
  parameter int ID_W = 8,
  parameter int CNT_W = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               iss_valid,
  output logic               iss_ready,
  input  logic [ID_W-1:0]    iss_src0,
  input  logic               iss_src0_en,
  input  logic [ID_W-1:0]    iss_src1,
  input  logic               iss_src1_en,
  input  logic [ID_W-1:0]    iss_dst,
  input  logic               iss_dst_en,
  input  logic               iss_flags_wr,
  input  logic               wb0_valid,
  input  logic [ID_W-1:0]    wb0_dst,
  input  logic               wb1_valid,
  input  logic [ID_W-1:0]    wb1_dst,
  input  logic               flush,
  output logic [REG_CNT-1:0] busy_vec,
  output logic               err,
  output logic [31:0]        stall_cnt
);
  localparam int FLAGS = 16;
  localparam int CMAX = 2 ** CNT_W - 1;
  logic [CNT_W-1:0] cnt [REG_CNT];
  logic [CNT_W-1:0] cnt_nxt [REG_CNT];
  logic [1:0] hit [REG_CNT];
  logic raw, waw, accept, busy, inc, err_nxt;
  int t;
  always_comb begin
    raw = 1'b0;
    waw = 1'b0;
    busy = 1'b0;
    for (int i = 0; i < REG_CNT; i++) begin
      hit[i] = {1'b0, wb0_valid && int'(wb0_dst) == i} + {1'b0, wb1_valid && int'(wb1_dst) == i};
`ifdef SB_WB_BYPASS_EN
      busy = int'(cnt[i]) > int'(hit[i]);
`else
      busy = cnt[i] != '0;
`endif
      raw = raw | (busy && ((iss_src0_en && int'(iss_src0) == i) || (iss_src1_en && int'(iss_src1) == i)));
      waw = waw | (int'(cnt[i]) == CMAX && ((iss_dst_en && int'(iss_dst) == i) || (iss_flags_wr && i == FLAGS)));
    end
    iss_ready = !flush && !raw && !waw;
    accept = iss_valid && iss_ready;
    // Out-of-range ids never match a counter, so they only contribute to err.
    err_nxt = (wb0_valid && int'(wb0_dst) >= REG_CNT) || (wb1_valid && int'(wb1_dst) >= REG_CNT) ||
              (accept && iss_dst_en && int'(iss_dst) >= REG_CNT);
    t = 0;
    inc = 1'b0;
    for (int i = 0; i < REG_CNT; i++) begin
      // dst==rflags together with flags_wr still bumps the counter only once.
      inc = accept && ((iss_dst_en && int'(iss_dst) == i) || (iss_flags_wr && i == FLAGS));
      t = int'(cnt[i]) + int'(inc) - int'(hit[i]);
      err_nxt = err_nxt | (t < 0);
      cnt_nxt[i] = t < 0 ? '0 : CNT_W'(t);
      busy_vec[i] = cnt[i] != '0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_CNT; i++) cnt[i] <= '0;
      err <= 1'b0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < REG_CNT; i++) cnt[i] <= flush ? '0 : cnt_nxt[i];
      err <= err | (err_nxt && !flush);
      if (iss_valid && !iss_ready && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
    end
  end
endmodule
